// File: rtl/wb_pkg.sv
// Shared widths and the write-request record for the writeback arbiter.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is hardwired zero: a write to it must never reach the register file.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer: power-of-two circular FIFO with wrapping pointers.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_req_t                din,
  output wb_req_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Single register-file write port shared by the ALU (priority) and buffered
// load results, plus a per-register scoreboard of loads still in flight.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  pend_set,
  input  logic [REG_ADDR_W-1:0] pend_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_req_t               fifo_din, fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  push, pop;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic [31:0]           pending_q, pending_d;

  // Readiness depends only on occupancy, so a full buffer refuses a load even
  // in a cycle where it is also draining one.
  assign ld_ready = ~rst & (fifo_count != CW'(FIFO_DEPTH));
  assign push     = ld_valid & ld_ready & ~fifo_full;
  assign pop      = ~alu_valid & ~fifo_empty;
  assign fifo_din = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_valid) begin
      rf_we_d    = writes_reg(alu_rd);
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end else if (pop) begin
      rf_we_d    = writes_reg(fifo_head.rd);
      rf_waddr_d = fifo_head.rd;
      rf_wdata_d = fifo_head.data;
    end
  end

  // Clear is applied before set so a same-cycle re-issue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (pop && writes_reg(fifo_head.rd)) pending_d[fifo_head.rd] = 1'b0;
    if (pend_set && writes_reg(pend_rd)) pending_d[pend_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rs1_busy = pending_q[chk_rs1] & writes_reg(chk_rs1);
  assign rs2_busy = pending_q[chk_rs2] & writes_reg(chk_rs2);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, load-result buffer entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_valid  input  1  ALU result present this cycle; no backpressure, always accepted.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 ld_valid  input  1  load result offered (valid/ready).
REQ-008 ld_ready  output  1  buffer can accept a load result.
REQ-009 ld_rd  input  5  load destination register.
REQ-010 ld_data  input  32  load data.
REQ-011 pend_set  input  1  issue stage marks pend_rd as awaiting a load.
REQ-012 pend_rd  input  5  register being marked pending.
REQ-013 chk_rs1, chk_rs2  input  5 each  source registers queried for hazards.
REQ-014 rs1_busy, rs2_busy  output  1 each  queried register has a pending load (combinational).
REQ-015 rf_we  output  1  register-file write enable (registered).
REQ-016 rf_waddr  output  5  register-file write address (registered).
REQ-017 rf_wdata  output  32  register-file write data (registered).

Function
REQ-018 Load transfer occurs on the cycle where ld_valid and ld_ready are both 1; entry {ld_rd, ld_data} is pushed into the FIFO.
REQ-019 ld_ready SHALL equal (count != FIFO_DEPTH); no same-cycle push-through when full, even if a pop occurs that cycle.
REQ-020 Each cycle, the source for the write port is chosen as: alu_valid -> ALU; else FIFO non-empty -> FIFO head (popped); else idle.
REQ-021 The chosen write is presented on rf_we/rf_waddr/rf_wdata on the next rising edge (latency 1); idle cycles drive rf_we=0 with waddr/wdata holding their previous values.
REQ-022 Writes with destination 0 SHALL never assert rf_we; an x0 FIFO entry is still popped and consumed.
REQ-023 FIFO ordering is strictly first-in-first-out; read/write pointers are log2(FIFO_DEPTH) bits and wrap from FIFO_DEPTH-1 to 0.
REQ-024 Simultaneous push and pop with the FIFO non-full and non-empty leaves count unchanged; push into an empty FIFO is not poppable until the following cycle.
REQ-025 Scoreboard: 32 pending bits; pend_set sets bit pend_rd next cycle; pend_rd=0 is ignored.
REQ-026 A pending bit is cleared on the cycle a FIFO entry with that rd is popped; ALU writes never clear pending bits.
REQ-027 Set and clear of the same register in one cycle: set wins.
REQ-028 rsN_busy = pending[chk_rsN]; always 0 for chk_rsN=0.
REQ-029 No ALU-starvation guard: continuous alu_valid stalls FIFO draining indefinitely; ld_ready drops when full.

Reset
REQ-030 While rst=1 at a clock edge: FIFO emptied (pointers and count 0), all pending bits 0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-031 ld_ready SHALL be 0 during the reset cycle and 1 on the first cycle after reset deasserts.
REQ-032 Reset asserted mid-operation discards all buffered load results and pending bits without issuing any write.

Structure
REQ-033 Package wb_pkg holds XLEN=32, REG_ADDR_W=5, and typedef wb_req_t {rd, data}.
REQ-034 The FIFO SHALL be a separate sub-module wb_fifo (parameterised depth, push/pop/full/empty/count); arbitration and scoreboard stay in wb_arbiter.

Verification
REQ-035 Load only: pend_set rd=5; ld rd=5 data=0xDEADBEEF, alu idle -> rs1_busy(5)=1 until pop; rf_we=1 waddr=5 wdata=0xDEADBEEF two cycles after handshake; busy 0 afterwards.
REQ-036 Collision: same cycle alu rd=3 data=0x11 and FIFO head rd=4 data=0x22 -> rd 3 written first, rd 4 the next cycle.
REQ-037 Full: alu_valid held high, push 4 loads -> ld_ready=0 after the 4th; drop alu_valid -> 4 writes in push order, ld_ready=1 after first pop.
REQ-038 x0: ALU rd=0 and load rd=0 -> rf_we never asserted; FIFO count returns to 0.
REQ-039 Set/clear race: pop of rd=7 and pend_set rd=7 same cycle -> pending[7] remains 1.
REQ-040 Reset with 3 entries buffered -> no writes follow; count=0, all busy 0, ld_ready=1 next cycle.
